// File: rtl/shift_right_seq_pkg.sv
// Shared constants, op encodings and FSM states for the sequential right shifter.
package shift_right_seq_pkg;

  localparam int WIDTH  = 16;
  localparam int STAGES = 4;
  localparam int K_W    = $clog2(STAGES);

  typedef enum logic [1:0] {
    OP_SRL = 2'b00,
    OP_SRA = 2'b01,
    OP_ROR = 2'b10,
    OP_RSV = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/shift_right_seq_if.sv
// Request/result bundle between the execute stage and the sequential shifter.
interface shift_right_seq_if;
  import shift_right_seq_pkg::*;

  logic             start;
  logic [WIDTH-1:0] In;
  logic [STAGES-1:0] Cnt;
  logic [1:0]       Op;
  logic [WIDTH-1:0] Out;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output start, In, Cnt, Op,
    input  Out, busy, done, err
  );

  modport slave (
    input  start, In, Cnt, Op,
    output Out, busy, done, err
  );

endinterface

// File: rtl/shift_right_stage.sv
// One combinational right-shift stage of fixed power-of-two amount.
module shift_right_stage
  import shift_right_seq_pkg::*;
#(
    parameter int AMOUNT = 1
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic             en_i,
    input  op_e              op_i,
    input  logic             fill_i,
    output logic [WIDTH-1:0] data_o
);

    always_comb begin
        data_o = data_i;
        if (en_i) begin
            case (op_i)
                OP_SRL:  data_o = {{AMOUNT{1'b0}}, data_i[WIDTH-1:AMOUNT]};
                OP_SRA:  data_o = {{AMOUNT{fill_i}}, data_i[WIDTH-1:AMOUNT]};
                OP_ROR:  data_o = {data_i[AMOUNT-1:0], data_i[WIDTH-1:AMOUNT]};
                default: data_o = data_i;
            endcase
        end
    end

endmodule

// File: rtl/shift_right_seq.sv
// Sequential 16-bit right shifter/rotator: one power-of-two stage per cycle,
// result registered on the last stage and flagged with a one-cycle done pulse.
module shift_right_seq
  import shift_right_seq_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    shift_right_seq_if.slave   bus
);

    localparam logic [K_W-1:0] K_LAST = K_W'(STAGES - 1);

    state_e             state_q, state_d;
    logic [K_W-1:0]     k_q, k_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [STAGES-1:0]  cnt_q, cnt_d;
    op_e                op_q, op_d;
    logic               fill_q, fill_d;
    logic [WIDTH-1:0]   out_q, out_d;

    logic [WIDTH-1:0]   stage_out [STAGES];
    logic [WIDTH-1:0]   stage_sel;

    // All four stages see the working register; k picks which one is live.
    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        shift_right_stage #(.AMOUNT(1 << g)) u_stage (
            .data_i (work_q),
            .en_i   (cnt_q[g] && (op_q != OP_RSV)),
            .op_i   (op_q),
            .fill_i (fill_q),
            .data_o (stage_out[g])
        );
    end

    assign stage_sel = stage_out[k_q];

    // NOTE: every register, including the datapath holding registers, is
    // cleared so an aborted operation leaves no stale operand behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            work_q  <= '0;
            cnt_q   <= '0;
            op_q    <= OP_SRL;
            fill_q  <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            fill_q  <= fill_d;
            out_q   <= out_d;
        end
    end

    // NOTE: defaults first so every path assigns every next-state value (no latches).
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        fill_d  = fill_q;
        out_d   = out_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    work_d  = bus.In;
                    cnt_d   = bus.Cnt;
                    op_d    = op_e'(bus.Op);
                    fill_d  = bus.In[WIDTH-1];
                    k_d     = '0;
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                work_d = stage_sel;
                k_d    = k_q + K_W'(1);
                if (k_q == K_LAST) begin
                    out_d   = (op_q == OP_RSV) ? '0 : stage_sel;
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.Out  = out_q;
    assign bus.busy = (state_q == ST_SHIFT);
    assign bus.done = (state_q == ST_DONE);
    assign bus.err  = (state_q == ST_DONE) && (op_q == OP_RSV);

endmodule

// File: tb/tb_shift_right_seq.sv
// Directed bench for shift_right_seq: hand-computed vectors, latency, handshake and reset.
module tb_shift_right_seq;
    import shift_right_seq_pkg::*;

    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;
    logic [15:0] last_out;

    shift_right_seq_if bus ();

    shift_right_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present a request before an edge (E0) and check busy right after capture.
    task automatic launch(input logic [15:0] in_v, input logic [3:0] cnt_v,
                          input logic [1:0] op_v, input string tag);
        @(negedge clk);
        bus.start = 1'b1;
        bus.In    = in_v;
        bus.Cnt   = cnt_v;
        bus.Op    = op_v;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.In    = ~in_v;
        bus.Cnt   = ~cnt_v;
        bus.Op    = 2'b00;
        check({tag, " busy@E0"}, 32'(bus.busy), 32'd1);
        check({tag, " done@E0"}, 32'(bus.done), 32'd0);
    endtask

    // Walk E1..E4: no done and stable Out while shifting, then the result.
    task automatic finish_op(input logic [15:0] exp_out, input logic exp_err, input string tag);
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("%s busy@E%0d", tag, i), 32'(bus.busy), 32'd1);
            check($sformatf("%s done@E%0d", tag, i), 32'(bus.done), 32'd0);
            check($sformatf("%s hold@E%0d", tag, i), 32'(bus.Out), 32'(last_out));
        end
        @(posedge clk);
        #1;
        check({tag, " done@E4"}, 32'(bus.done), 32'd1);
        check({tag, " busy@E4"}, 32'(bus.busy), 32'd0);
        check({tag, " out"},     32'(bus.Out),  32'(exp_out));
        check({tag, " err"},     32'(bus.err),  32'(exp_err));
        last_out = exp_out;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        last_out     = 16'h0000;
        bus.start = 1'b0;
        bus.In    = '0;
        bus.Cnt   = '0;
        bus.Op    = '0;

        // Reset state
        rst = 1'b1;
        #12;
        check("rst out",  32'(bus.Out),  32'h0);
        check("rst busy", 32'(bus.busy), 32'd0);
        check("rst done", 32'(bus.done), 32'd0);
        check("rst err",  32'(bus.err),  32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // Main function
        launch(16'h8F00, 4'd4, 2'b00, "srl");
        finish_op(16'h08F0, 1'b0, "srl");
        @(posedge clk);
        #1;
        check("srl done one cycle", 32'(bus.done), 32'd0);
        check("srl out holds",      32'(bus.Out),  32'h08F0);

        launch(16'h8F00, 4'd4, 2'b01, "sra4");
        finish_op(16'hF8F0, 1'b0, "sra4");
        repeat (2) @(posedge clk);
        launch(16'h8000, 4'd15, 2'b01, "sra15");
        finish_op(16'hFFFF, 1'b0, "sra15");
        repeat (2) @(posedge clk);
        launch(16'h1234, 4'd8, 2'b10, "ror8");
        finish_op(16'h3412, 1'b0, "ror8");
        repeat (2) @(posedge clk);
        launch(16'h0001, 4'd15, 2'b10, "ror15");
        finish_op(16'h0002, 1'b0, "ror15");
        repeat (2) @(posedge clk);

        // Cnt=0 boundary for each op
        launch(16'hA5A5, 4'd0, 2'b00, "cnt0 srl");
        finish_op(16'hA5A5, 1'b0, "cnt0 srl");
        repeat (2) @(posedge clk);
        launch(16'hA5A5, 4'd0, 2'b01, "cnt0 sra");
        finish_op(16'hA5A5, 1'b0, "cnt0 sra");
        repeat (2) @(posedge clk);
        launch(16'hA5A5, 4'd0, 2'b10, "cnt0 ror");
        finish_op(16'hA5A5, 1'b0, "cnt0 ror");
        repeat (2) @(posedge clk);

        // Reserved op
        launch(16'hA5A5, 4'd5, 2'b11, "rsv");
        finish_op(16'h0000, 1'b1, "rsv");
        @(posedge clk);
        #1;
        check("rsv err one cycle", 32'(bus.err), 32'd0);
        repeat (2) @(posedge clk);

        // start held during SHIFT with different operands is ignored
        launch(16'h00F0, 4'd4, 2'b00, "held");
        bus.start = 1'b1;
        bus.In    = 16'hFFFF;
        bus.Cnt   = 4'd1;
        bus.Op    = 2'b01;
        finish_op(16'h000F, 1'b0, "held");
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        check("held idle after done", 32'(bus.busy), 32'd0);
        repeat (2) @(posedge clk);

        // Back-to-back: second start lands in the DONE cycle
        launch(16'hF000, 4'd12, 2'b00, "b2b first");
        finish_op(16'h000F, 1'b0, "b2b first");
        launch(16'h00C3, 4'd2, 2'b10, "b2b second");
        finish_op(16'hC030, 1'b0, "b2b second");
        repeat (2) @(posedge clk);

        // Reset at E2 of an SRL on 0xFFFF aborts with no done
        launch(16'hFFFF, 4'd1, 2'b00, "abort");
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("abort out",  32'(bus.Out),  32'h0);
        check("abort busy", 32'(bus.busy), 32'd0);
        check("abort done", 32'(bus.done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        last_out = 16'h0000;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("abort no done %0d", i), 32'(bus.done), 32'd0);
        end
        launch(16'hFFFF, 4'd1, 2'b00, "post rst");
        finish_op(16'h7FFF, 1'b0, "post rst");

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
